// File: rtl/tl_pkg.sv
// Shared phase encodings, light codes and BCD helpers for the traffic light controller.
package tl_pkg;

  localparam logic [2:0] RED0 = 3'd0;
  localparam logic [2:0] NS_G = 3'd1;
  localparam logic [2:0] NS_Y = 3'd2;
  localparam logic [2:0] RED1 = 3'd3;
  localparam logic [2:0] EW_G = 3'd4;
  localparam logic [2:0] EW_Y = 3'd5;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  function automatic logic [7:0] to_bcd(input int v);
    int t;
    int o;
    t = v / 10;
    o = v % 10;
    return {t[3:0], o[3:0]};
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Ones borrow from tens when they underflow; callers never decrement 0x00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
    else return {b[7:4], b[3:0] - 4'd1};
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] s);
    case (s)
      RED0:    return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return RED1;
      RED1:    return EW_G;
      EW_G:    return EW_Y;
      default: return RED0;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: tick is the combinational wrap strobe, sec_tick its registered copy.
module sec_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic sec_tick
);

  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [W-1:0] pre;

  assign tick = en && (pre == W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
      if (en) pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection phase sequencer with BCD seconds countdown and pedestrian shortening.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int GREEN_S     = 30,
  parameter int YELLOW_S    = 3,
  parameter int RED_CLR_S   = 2,
  parameter int PED_S       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic [2:0] phase,
  output logic       sec_tick
);

  logic       tick;
  logic [2:0] state, state_nxt;
  logic [7:0] count, count_nxt;
  logic       ped_pend, ped_nxt;
  logic [2:0] ns_nxt, ew_nxt;

  function automatic logic [7:0] dur_bcd(input logic [2:0] s);
    case (s)
      NS_G, EW_G: return to_bcd(GREEN_S);
      NS_Y, EW_Y: return to_bcd(YELLOW_S);
      default:    return to_bcd(RED_CLR_S);
    endcase
  endfunction

  sec_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick     (tick),
    .sec_tick (sec_tick)
  );

  // State, count, pedestrian latch and lights all move on the same edge as the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RED0;
      count    <= to_bcd(RED_CLR_S);
      ped_pend <= 1'b0;
      light_ns <= L_RED;
      light_ew <= L_RED;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      ped_pend <= ped_nxt;
      light_ns <= ns_nxt;
      light_ew <= ew_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (state > EW_Y) begin
      state_nxt = RED0;
      count_nxt = to_bcd(RED_CLR_S);
    end else if (tick) begin
      if (count == 8'h01) begin
        state_nxt = next_phase(state);
        count_nxt = dur_bcd(state_nxt);
      end else if ((state == NS_G || state == EW_G) && ped_pend && bcd_val(count) > PED_S) begin
        count_nxt = to_bcd(PED_S);
      end else begin
        count_nxt = bcd_dec(count);
      end
    end
  end

  // A request seen in the same cycle as a red entry survives into that red phase.
  always_comb begin
    ped_nxt = ped_pend;
    if (state_nxt != state && (state_nxt == RED0 || state_nxt == RED1)) ped_nxt = 1'b0;
    if (ped_req) ped_nxt = 1'b1;
  end

  always_comb begin
    ns_nxt = L_RED;
    ew_nxt = L_RED;
    case (state_nxt)
      NS_G:    ns_nxt = L_GRN;
      NS_Y:    ns_nxt = L_YEL;
      EW_G:    ew_nxt = L_GRN;
      EW_Y:    ew_nxt = L_YEL;
      default: ;
    endcase
  end

  assign cnt_tens = count[7:4];
  assign cnt_ones = count[3:0];
  assign phase    = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized and directed bench for traffic_light_ctrl against a seconds-level phase model.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       ped_req = 1'b0;
  logic [2:0] light_ns, light_ew, phase;
  logic [3:0] cnt_tens, cnt_ones;
  logic       sec_tick;

  int checks = 0;
  int errors = 0;

  traffic_light_ctrl #(
    .TICK_CYCLES(4), .GREEN_S(12), .YELLOW_S(3), .RED_CLR_S(2), .PED_S(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
    .light_ns(light_ns), .light_ew(light_ew),
    .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
    .phase(phase), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  // Model: phase index walks the six-phase cycle, seconds remaining kept as a plain integer.
  int       dur [6] = '{2, 12, 3, 2, 12, 3};
  logic [2:0] ns_l [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_l [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  int m_idx, m_rem, m_pre;
  bit m_ped, m_tick;

  wire [17:0] dut_vec = {light_ns, light_ew, cnt_tens, cnt_ones, phase, sec_tick};

  function automatic logic [17:0] exp_vec();
    logic [3:0] t, o;
    logic [2:0] p;
    t = 4'(m_rem / 10);
    o = 4'(m_rem % 10);
    p = 3'(m_idx);
    return {ns_l[m_idx], ew_l[m_idx], t, o, p, m_tick};
  endfunction

  task automatic model_reset();
    m_idx = 0; m_rem = 2; m_pre = 0; m_ped = 0; m_tick = 0;
  endtask

  task automatic model_clk(input bit en_v, input bit ped_v);
    bit wrap;
    int old_idx;
    wrap = en_v && (m_pre == 3);
    old_idx = m_idx;
    m_tick = wrap;
    if (en_v) m_pre = wrap ? 0 : m_pre + 1;
    if (wrap) begin
      if (m_rem == 1) begin
        m_idx = (m_idx + 1) % 6;
        m_rem = dur[m_idx];
      end else if ((m_idx == 1 || m_idx == 4) && m_ped && m_rem > 5) m_rem = 5;
      else m_rem = m_rem - 1;
    end
    if (m_idx != old_idx && (m_idx == 0 || m_idx == 3)) m_ped = 0;
    if (ped_v) m_ped = 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_clk(en, ped_req);
    #1;
  endtask

  task automatic run_until(input int idx, input int rem, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (m_idx == idx && m_rem == rem) begin ok = 1; return; end
    end
  endtask

  task automatic run_to_tick(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (m_tick) begin n = i; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; #2; rst = 1'b1; #2;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_vec, exp_vec());
    end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_seq cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({phase, light_ns, light_ew, cnt_tens, cnt_ones} !== {3'd1, 3'b001, 3'b100, 8'h12}) begin
      errors++; $display("FAIL first_ns_g got %h want %h",
        {phase, light_ns, light_ew, cnt_tens, cnt_ones}, {3'd1, 3'b001, 3'b100, 8'h12});
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 128; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec() || (light_ns != 3'b100 && light_ew != 3'b100)) begin
        errors++; $display("FAIL free_run cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({phase, cnt_tens, cnt_ones} !== {3'd0, 8'h02}) begin
      errors++; $display("FAIL cycle_136 got %h want %h", {phase, cnt_tens, cnt_ones}, {3'd0, 8'h02});
    end
  endtask

  task automatic test_bcd_borrow();
    bit ok;
    int n;
    run_until(1, 10, 200, ok);
    run_to_tick(8, n);
    checks++;
    if (!ok || n < 0 || {phase, cnt_tens, cnt_ones} !== {3'd1, 8'h09}) begin
      errors++; $display("FAIL borrow_10_09 got %h want %h", {phase, cnt_tens, cnt_ones}, {3'd1, 8'h09});
    end
    run_until(1, 1, 200, ok);
    run_to_tick(8, n);
    checks++;
    if (!ok || n < 0 || {phase, light_ns, cnt_tens, cnt_ones} !== {3'd2, 3'b010, 8'h03}) begin
      errors++; $display("FAIL green_to_yellow got %h want %h",
        {phase, light_ns, cnt_tens, cnt_ones}, {3'd2, 3'b010, 8'h03});
    end
  endtask

  task automatic test_ped();
    bit ok;
    int n;
    run_until(4, 11, 300, ok);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run_to_tick(8, n);
    checks++;
    if (!ok || n < 0 || {phase, cnt_tens, cnt_ones} !== {3'd4, 8'h05}) begin
      errors++; $display("FAIL ped_shorten got %h want %h", {phase, cnt_tens, cnt_ones}, {3'd4, 8'h05});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ped_tail cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({phase, light_ew, cnt_tens, cnt_ones} !== {3'd5, 3'b010, 8'h03}) begin
      errors++; $display("FAIL ped_to_ew_y got %h want %h",
        {phase, light_ew, cnt_tens, cnt_ones}, {3'd5, 3'b010, 8'h03});
    end
    run_until(1, 4, 300, ok);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run_to_tick(8, n);
    checks++;
    if (!ok || n < 0 || {phase, cnt_tens, cnt_ones} !== {3'd1, 8'h03}) begin
      errors++; $display("FAIL ped_late got %h want %h", {phase, cnt_tens, cnt_ones}, {3'd1, 8'h03});
    end
    run_until(4, 3, 300, ok);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run_until(1, 12, 300, ok);
    run_to_tick(8, n);
    checks++;
    if (!ok || n < 0 || {phase, cnt_tens, cnt_ones} !== {3'd1, 8'h11}) begin
      errors++; $display("FAIL ped_cleared_red0 got %h want %h", {phase, cnt_tens, cnt_ones}, {3'd1, 8'h11});
    end
  endtask

  task automatic test_enable();
    bit ok;
    int n;
    logic [17:0] held;
    run_until(2, 2, 300, ok);
    step(); step();
    held = dut_vec;
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (!ok || dut_vec !== held || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL en_hold cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    en = 1'b1;
    run_to_tick(8, n);
    checks++;
    if (n != 2 || {phase, cnt_tens, cnt_ones} !== {3'd2, 8'h01}) begin
      errors++; $display("FAIL en_resume got %0d/%h want 2/%h", n, {phase, cnt_tens, cnt_ones}, {3'd2, 8'h01});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 24) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec() || (light_ns != 3'b100 && light_ew != 3'b100)) begin
        errors++; $display("FAIL random cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    en = 1'b1;
    ped_req = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    run_until(5, 2, 300, ok);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    model_reset();
    checks++;
    if (!ok || {light_ns, light_ew, cnt_tens, cnt_ones, phase} !== {3'b100, 3'b100, 8'h02, 3'd0}) begin
      errors++; $display("FAIL async_rst got %h want %h",
        {light_ns, light_ew, cnt_tens, cnt_ones, phase}, {3'b100, 3'b100, 8'h02, 3'd0});
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rst_restart cyc %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({phase, cnt_tens, cnt_ones} !== {3'd1, 8'h12}) begin
      errors++; $display("FAIL restart_ns_g got %h want %h", {phase, cnt_tens, cnt_ones}, {3'd1, 8'h12});
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_bcd_borrow();
    test_ped();
    test_enable();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
